// File: rtl/intc_src.sv
// External interrupt controller: synchronises device lines, applies polarity and
// trigger mode, latches pending edges and routes enabled sources onto CP0 HW0..HW5.
module intc_src #(
    parameter int unsigned NSRC      = 8,
    parameter logic [31:0] BASE_ADDR = 32'h1fd0_1000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] dev_irq,
    input  logic            req,
    input  logic            wr,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    output logic            addr_ok,
    output logic            data_ok,
    output logic [31:0]     rdata,
    output logic [7:0]      cpu_int
);

    localparam logic [3:0] A_RAW   = 4'h0;
    localparam logic [3:0] A_EN    = 4'h1;
    localparam logic [3:0] A_EDGE  = 4'h2;
    localparam logic [3:0] A_POL   = 4'h3;
    localparam logic [3:0] A_PEND  = 4'h4;
    localparam logic [3:0] A_ROUTE = 4'h5;

    typedef enum logic {S_IDLE, S_RESP} bus_state_e;

    bus_state_e            r_state;
    bus_state_e            w_state_nxt;
    logic                  w_accept;

    logic [NSRC-1:0]       r_sync1;
    logic [NSRC-1:0]       r_sync2;
    logic [NSRC-1:0]       r_act_d;
    logic [NSRC-1:0]       r_en;
    logic [NSRC-1:0]       r_edge;
    logic [NSRC-1:0]       r_pol;
    logic [NSRC-1:0]       r_latch;
    logic [3*NSRC-1:0]     r_route;
    logic [5:0]            r_cpu_int;
    logic [31:0]           r_rdata;

    logic [3:0]            w_sel;
    logic                  w_wr;
    logic [NSRC-1:0]       w_act;
    logic [NSRC-1:0]       w_rise;
    logic [NSRC-1:0]       w_pend;
    logic [NSRC-1:0]       w_clr;
    logic [NSRC-1:0]       w_edge_nxt;
    logic [NSRC-1:0]       w_latch_nxt;
    logic [5:0]            w_cpu_nxt;
    logic [31:0]           w_rd_mux;
    logic                  w_unused;

    // Upper address bits are already decoded by the crossbar.
    assign w_unused = ^{addr[31:6], addr[1:0], wdata, BASE_ADDR};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign addr_ok = (r_state == S_IDLE);
    assign data_ok = (r_state == S_RESP) & ~reset;
    assign rdata   = reset ? '0 : r_rdata;
    assign cpu_int = {r_cpu_int, 2'b00};

    assign w_sel  = addr[5:2];
    assign w_wr   = w_accept & wr;
    assign w_act  = r_sync2 ^ r_pol;
    assign w_rise = w_act & ~r_act_d;
    assign w_pend = (r_edge & r_latch) | (~r_edge & w_act);

    assign w_edge_nxt = (w_wr && w_sel == A_EDGE) ? wdata[NSRC-1:0] : r_edge;
    assign w_clr      = (w_wr && w_sel == A_PEND) ? wdata[NSRC-1:0] : '0;
    // A new edge beats a same-cycle clear; clearing EDGE drops any held latch.
    assign w_latch_nxt = ((r_latch & ~w_clr) | w_rise) & w_edge_nxt;

    always_comb begin
        w_cpu_nxt = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            for (int unsigned k = 0; k < 6; k++) begin
                if (w_pend[i] && r_en[i] && r_route[3*i +: 3] == 3'(k)) begin
                    w_cpu_nxt[k] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (w_sel)
            A_RAW:   w_rd_mux[NSRC-1:0]   = w_act;
            A_EN:    w_rd_mux[NSRC-1:0]   = r_en;
            A_EDGE:  w_rd_mux[NSRC-1:0]   = r_edge;
            A_POL:   w_rd_mux[NSRC-1:0]   = r_pol;
            A_PEND:  w_rd_mux[NSRC-1:0]   = w_pend;
            A_ROUTE: w_rd_mux[3*NSRC-1:0] = r_route;
            default: w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_act_d   <= '0;
            r_en      <= '0;
            r_edge    <= '0;
            r_pol     <= '0;
            r_latch   <= '0;
            r_route   <= '0;
            r_cpu_int <= '0;
            r_rdata   <= '0;
        end else begin
            r_sync1   <= dev_irq;
            r_sync2   <= r_sync1;
            r_act_d   <= w_act;
            r_edge    <= w_edge_nxt;
            r_latch   <= w_latch_nxt;
            r_cpu_int <= w_cpu_nxt;
            r_rdata   <= (w_accept && !wr) ? w_rd_mux : '0;
            if (w_wr && w_sel == A_EN)    r_en    <= wdata[NSRC-1:0];
            if (w_wr && w_sel == A_POL)   r_pol   <= wdata[NSRC-1:0];
            if (w_wr && w_sel == A_ROUTE) r_route <= wdata[3*NSRC-1:0];
        end
    end

endmodule
